// File: rtl/div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_pkg: shared state encoding, default width and helpers for signed_divider
// Rev 1.0
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    DIV      = 3'd2,
    FIX      = 3'd3,
    DONE     = 3'd4,
    WAIT_REL = 3'd5
  } state_e;

  // Bit pattern of the most negative two's-complement value of the given width
  function automatic logic [31:0] min_signed(input int unsigned width);
    min_signed = 32'd1 << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_datapath: restoring shift-subtract core with sign handling and result regs
// Rev 1.0
// ---------------------------------------------------------------------------
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             divisor_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_signed(WIDTH));

  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH+1:0] p_sh;
  logic [WIDTH+1:0] t;

  assign divisor_zero = (divisor == '0);

  // One extra guard bit on the trial difference makes its MSB a clean sign
  assign p_sh = {p_q, q_q[WIDTH-1]};
  assign t    = p_sh - {2'b00, dmag_q};

  always_comb begin
    p_d        = p_q;
    q_d        = q_q;
    dmag_d     = dmag_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    ovf_pend_d = ovf_pend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    if (load) begin
      p_d        = '0;
      q_d        = dividend[WIDTH-1] ? -dividend : dividend;
      dmag_d     = divisor[WIDTH-1] ? -divisor : divisor;
      qneg_d     = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_d     = dividend[WIDTH-1];
      ovf_pend_d = (dividend == MIN_VAL) && (divisor == '1);
      ovf_d      = 1'b0;
      dbz_d      = divisor_zero;
      if (divisor_zero) begin
        quot_d = '0;
        rem_d  = dividend;
      end
    end else if (step) begin
      q_d = {q_q[WIDTH-2:0], ~t[WIDTH+1]};
      p_d = t[WIDTH+1] ? p_sh[WIDTH:0] : t[WIDTH:0];
    end else if (fix) begin
      quot_d = qneg_q ? -q_q : q_q;
      rem_d  = rneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
      ovf_d  = ovf_pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q        <= '0;
      q_q        <= '0;
      dmag_q     <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      p_q        <= p_d;
      q_q        <= q_d;
      dmag_q     <= dmag_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      ovf_pend_q <= ovf_pend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: rtl/signed_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signed_divider: Run-handshaked sequential signed divider (control FSM + counter)
// Rev 1.0
// ---------------------------------------------------------------------------
module signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             Overflow
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divisor_zero;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:     if (Run) state_d = LOAD;
      LOAD: begin
        cnt_d   = CNT_LAST;
        state_d = divisor_zero ? DONE : DIV;
      end
      DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX:      state_d = DONE;
      DONE:     if (!Run) state_d = WAIT_REL;
      WAIT_REL: if (Run) state_d = LOAD;
      default:  state_d = IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they appear registered
  always_comb begin
    busy_d = (state_d == LOAD) || (state_d == DIV) || (state_d == FIX);
    done_d = (state_d == DONE) || (state_d == WAIT_REL);
  end

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .load         (state_q == LOAD),
    .step         (state_q == DIV),
    .fix          (state_q == FIX),
    .dividend     (Dividend),
    .divisor      (Divisor),
    .divisor_zero (divisor_zero),
    .quotient     (Quotient),
    .remainder    (Remainder),
    .div_by_zero  (DivByZero),
    .overflow     (Overflow)
  );

  assign Busy = busy_q;
  assign Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_signed_divider: directed vector table plus handshake/reset sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_signed_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] dividend, divisor;
  logic [7:0] quotient, remainder;
  logic       busy, done, dbz, ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  signed_divider #(.WIDTH(8)) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .Run       (run),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Quotient  (quotient),
    .Remainder (remainder),
    .Busy      (busy),
    .Done      (done),
    .DivByZero (dbz),
    .Overflow  (ovf)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start an operation; Run is dropped in LOAD unless hold is set. Operands are
  // scrambled during DIV to show they are only sampled in LOAD.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit hold,
                       output int lat, output int busy_bad);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    run      = 1'b1;
    @(posedge clk);
    lat      = -1;
    busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) run = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_bad++;
      if (c == 2) begin
        dividend = ~a;
        divisor  = b ^ 8'h5A;
      end
    end
  endtask

  initial begin
    int lat, bb, viol;

    vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 11};
    vecs[1]  = '{8'h9C,  8'h07,  8'hF2, 8'hFE, 1'b0, 1'b0, 11};
    vecs[2]  = '{8'h64,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 11};
    vecs[3]  = '{8'h25,  8'h00,  8'h00, 8'h25, 1'b1, 1'b0, 2};
    vecs[4]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 11};
    vecs[5]  = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 11};
    vecs[6]  = '{8'h7F,  8'h03,  8'h2A, 8'h01, 1'b0, 1'b0, 11};
    vecs[7]  = '{8'hF9,  8'h02,  8'hFD, 8'hFF, 1'b0, 1'b0, 11};
    vecs[8]  = '{8'h07,  8'hFE,  8'hFD, 8'h01, 1'b0, 1'b0, 11};
    vecs[9]  = '{8'h80,  8'h07,  8'hEE, 8'hFE, 1'b0, 1'b0, 11};
    vecs[10] = '{8'h00,  8'h05,  8'h00, 8'h00, 1'b0, 1'b0, 11};
    vecs[11] = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 11};
    vecs[12] = '{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 11};

    rst_n    = 1'b0;
    run      = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_quotient",  {24'd0, quotient},  32'h0);
    chk("reset_remainder", {24'd0, remainder}, 32'h0);
    chk("reset_busy",      {31'd0, busy},      32'h0);
    chk("reset_done",      {31'd0, done},      32'h0);
    chk("reset_dbz",       {31'd0, dbz},       32'h0);
    chk("reset_ovf",       {31'd0, ovf},       32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b0, lat, bb);
      chk($sformatf("v%0d_latency", i),   lat,                       vecs[i].lat);
      chk($sformatf("v%0d_quotient", i),  {24'd0, quotient},         {24'd0, vecs[i].q});
      chk($sformatf("v%0d_remainder", i), {24'd0, remainder},        {24'd0, vecs[i].r});
      chk($sformatf("v%0d_dbz", i),       {31'd0, dbz},              {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_ovf", i),       {31'd0, ovf},              {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d_busy_window", i), bb,                      0);
      chk($sformatf("v%0d_busy_in_done", i), {31'd0, busy},          32'h0);
    end

    // Run held through DONE: one operation only, results stay put
    do_op(8'd100, 8'd7, 1'b1, lat, bb);
    chk("held_latency",  lat,                11);
    chk("held_quotient", {24'd0, quotient},  32'h0E);
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!done || busy || quotient !== 8'h0E || remainder !== 8'h02) viol++;
    end
    chk("held_run_stable", viol, 0);
    run = 1'b0;
    @(negedge clk);
    chk("wait_rel_done",     {31'd0, done},     32'h1);
    chk("wait_rel_quotient", {24'd0, quotient}, 32'h0E);
    do_op(8'd50, 8'd5, 1'b0, lat, bb);
    chk("second_latency",   lat,               11);
    chk("second_quotient",  {24'd0, quotient},  32'h0A);
    chk("second_remainder", {24'd0, remainder}, 32'h00);

    // Reset in the fifth DIV cycle discards the division and clears outputs
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    run      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_quotient",  {24'd0, quotient},  32'h0);
    chk("midreset_remainder", {24'd0, remainder}, 32'h0);
    chk("midreset_busy",      {31'd0, busy},      32'h0);
    chk("midreset_done",      {31'd0, done},      32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset_busy", {31'd0, busy}, 32'h0);
    do_op(8'd127, 8'd3, 1'b0, lat, bb);
    chk("post_reset_latency",   lat,                11);
    chk("post_reset_quotient",  {24'd0, quotient},  32'h2A);
    chk("post_reset_remainder", {24'd0, remainder}, 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
